buzzer_seq: RTL and testbench



---
 rtl/buzzer_seq.sv | 162 ++++++++++++++++
 tb/tb_buzzer_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_seq.sv
// buzzer_seq: burst beeper. A start request in IDLE latches the tone/duration/
// repeat settings and plays repeat_n beeps (0 = forever) of on_cycles each,
// separated by off_cycles of silence. The tone is either a square wave of
// half-period tone_half or, with tone_half == 0, a steady DC level.
module buzzer_seq #(
  parameter int unsigned TONE_W   = 18,
  parameter int unsigned DUR_W    = 27,
  parameter int unsigned REP_W    = 4,
  parameter logic        IDLE_LVL = 1'b0
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              abort,
  input  logic [TONE_W-1:0] tone_half,
  input  logic [DUR_W-1:0]  on_cycles,
  input  logic [DUR_W-1:0]  off_cycles,
  input  logic [REP_W-1:0]  repeat_n,
  output logic              beep,
  output logic              busy,
  output logic              done,
  output logic [REP_W-1:0]  beep_idx
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2
  } state_e;

  localparam logic [TONE_W-1:0] TONE_ONE = TONE_W'(1);
  localparam logic [DUR_W-1:0]  DUR_ONE  = DUR_W'(1);
  localparam logic [REP_W-1:0]  REP_ONE  = REP_W'(1);

  state_e             state_q;
  logic [TONE_W-1:0]  tone_half_q;
  logic [TONE_W-1:0]  tone_cnt_q;
  logic [DUR_W-1:0]   on_cyc_q;
  logic [DUR_W-1:0]   off_cyc_q;
  logic [DUR_W-1:0]   dur_cnt_q;
  logic [REP_W-1:0]   rep_q;
  logic [REP_W-1:0]   idx_q;
  logic               beep_q;
  logic               busy_q;
  logic               done_q;

  logic               tone_wrap_d;
  logic               on_end_d;
  logic               off_end_d;
  logic               last_beep_d;
  logic               beep_start_d;
  logic [REP_W-1:0]   idx_d;

  // Decode end-of-interval conditions against the latched burst settings.
  always_comb begin
    tone_wrap_d  = (tone_cnt_q == (tone_half_q - TONE_ONE));
    on_end_d     = (dur_cnt_q == (on_cyc_q - DUR_ONE));
    off_end_d    = (dur_cnt_q == (off_cyc_q - DUR_ONE));
    last_beep_d  = (rep_q != '0) && (idx_q == (rep_q - REP_ONE));
    beep_start_d = (tone_half_q == '0) ? ~IDLE_LVL : IDLE_LVL;
    idx_d        = idx_q + REP_ONE;  // wraps naturally in infinite mode
  end

  // Burst sequencer: IDLE -> ON (-> OFF -> ON ...) -> IDLE, outputs registered.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_IDLE;
      tone_half_q <= '0;
      tone_cnt_q  <= '0;
      on_cyc_q    <= '0;
      off_cyc_q   <= '0;
      dur_cnt_q   <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      beep_q      <= IDLE_LVL;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start && !abort) begin
            tone_half_q <= tone_half;
            on_cyc_q    <= (on_cycles == '0) ? DUR_ONE : on_cycles;
            off_cyc_q   <= off_cycles;
            rep_q       <= repeat_n;
            state_q     <= ST_ON;
            busy_q      <= 1'b1;
            idx_q       <= '0;
            dur_cnt_q   <= '0;
            tone_cnt_q  <= '0;
            beep_q      <= (tone_half == '0) ? ~IDLE_LVL : IDLE_LVL;
          end
        end
        ST_ON: begin
          if (abort) begin
            state_q    <= ST_IDLE;
            beep_q     <= IDLE_LVL;
            busy_q     <= 1'b0;
            done_q     <= 1'b1;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
          end else if (on_end_d) begin
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            if (last_beep_d) begin
              state_q <= ST_IDLE;
              beep_q  <= IDLE_LVL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else if (off_cyc_q == '0) begin
              // Back-to-back beeps: tone phase restarts with each beep.
              idx_q  <= idx_d;
              beep_q <= beep_start_d;
            end else begin
              state_q <= ST_OFF;
              beep_q  <= IDLE_LVL;
            end
          end else begin
            dur_cnt_q <= dur_cnt_q + DUR_ONE;
            if (tone_half_q != '0) begin
              if (tone_wrap_d) begin
                tone_cnt_q <= '0;
                beep_q     <= ~beep_q;
              end else begin
                tone_cnt_q <= tone_cnt_q + TONE_ONE;
              end
            end
          end
        end
        ST_OFF: begin
          if (abort) begin
            state_q   <= ST_IDLE;
            beep_q    <= IDLE_LVL;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            dur_cnt_q <= '0;
          end else if (off_end_d) begin
            state_q    <= ST_ON;
            idx_q      <= idx_d;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            beep_q     <= beep_start_d;
          end else begin
            dur_cnt_q <= dur_cnt_q + DUR_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          beep_q  <= IDLE_LVL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign beep     = beep_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign beep_idx = idx_q;

endmodule

// File: tb/tb_buzzer_seq.sv
// tb_buzzer_seq: directed bursts for buzzer_seq, checked every cycle against a
// timeline model (beep number and phase derived from time since burst start)
// plus hand-computed cycle expectations.
module tb_buzzer_seq;
  localparam int unsigned TONE_W   = 18;
  localparam int unsigned DUR_W    = 27;
  localparam int unsigned REP_W    = 4;
  localparam logic        IDLE_LVL = 1'b0;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [TONE_W-1:0] tone_half = '0;
  logic [DUR_W-1:0]  on_cycles = '0;
  logic [DUR_W-1:0]  off_cycles = '0;
  logic [REP_W-1:0]  repeat_n = '0;
  logic              beep;
  logic              busy;
  logic              done;
  logic [REP_W-1:0]  beep_idx;

  always #5 clk = ~clk;

  buzzer_seq #(
    .TONE_W(TONE_W), .DUR_W(DUR_W), .REP_W(REP_W), .IDLE_LVL(IDLE_LVL)
  ) dut (
    .clk(clk), .rstn(rstn), .start(start), .abort(abort),
    .tone_half(tone_half), .on_cycles(on_cycles), .off_cycles(off_cycles),
    .repeat_n(repeat_n), .beep(beep), .busy(busy), .done(done),
    .beep_idx(beep_idx)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- timeline model ----------------
  bit               m_busy = 1'b0;
  bit               m_done = 1'b0;
  longint           m_t = 0;
  longint           c_tone = 0, c_on = 1, c_off = 0, c_rep = 0;
  logic [REP_W-1:0] m_idx_hold = '0;

  function automatic logic [REP_W-1:0] f_idx();
    longint p;
    p = c_on + c_off;
    return REP_W'(m_t / p);
  endfunction

  function automatic logic f_beep();
    longint p, r;
    p = c_on + c_off;
    r = m_t % p;
    if (r >= c_on) return IDLE_LVL;
    if (c_tone == 0) return ~IDLE_LVL;
    return IDLE_LVL ^ (((r / c_tone) % 2) != 0);
  endfunction

  task automatic model_step();
    if (!rstn) begin
      m_busy = 1'b0; m_done = 1'b0; m_t = 0; m_idx_hold = '0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        if (abort) begin
          m_idx_hold = f_idx(); m_busy = 1'b0; m_done = 1'b1;
        end else begin
          m_t++;
          if (c_rep != 0 && m_t == c_rep * c_on + (c_rep - 1) * c_off) begin
            m_idx_hold = REP_W'(c_rep - 1); m_busy = 1'b0; m_done = 1'b1;
          end
        end
      end else if (start && !abort) begin
        c_tone = longint'(tone_half);
        c_on   = (on_cycles == '0) ? 1 : longint'(on_cycles);
        c_off  = longint'(off_cycles);
        c_rep  = longint'(repeat_n);
        m_busy = 1'b1;
        m_t    = 0;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  // Per-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      chk("m_busy", busy, m_busy);
      chk("m_done", done, m_done);
      chk("m_beep", beep, m_busy ? f_beep() : IDLE_LVL);
      chk("m_idx", beep_idx, m_busy ? f_idx() : m_idx_hold);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cfg(input int t, input int on, input int off, input int rep);
    tone_half  = TONE_W'(t);
    on_cycles  = DUR_W'(on);
    off_cycles = DUR_W'(off);
    repeat_n   = REP_W'(rep);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int busy_n, done_n, done_at, high_n;

    // Reset values while rstn held low.
    step(); step();
    chk("rst_beep", beep, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_idx", beep_idx, 0);
    rstn = 1'b1;
    step();

    // Single tone beep: toggles at 5,9,13,17, done at 21.
    cfg(4, 20, 0, 1); start = 1'b1;
    for (int c = 1; c <= 22; c++) begin
      step();
      if (c == 1) begin start = 1'b0; chk("t2_busy1", busy, 1); chk("t2_beep1", beep, 0); end
      if (c == 4)  chk("t2_beep4", beep, 0);
      if (c == 5)  chk("t2_beep5", beep, 1);
      if (c == 9)  chk("t2_beep9", beep, 0);
      if (c == 13) chk("t2_beep13", beep, 1);
      if (c == 20) begin chk("t2_busy20", busy, 1); chk("t2_done20", done, 0); end
      if (c == 21) begin chk("t2_done21", done, 1); chk("t2_busy21", busy, 0); chk("t2_beep21", beep, 0); end
      if (c == 22) chk("t2_done22", done, 0);
    end
    step();

    // Three beeps with gap, plus an ignored start pulse mid-burst.
    cfg(2, 8, 5, 3); start = 1'b1;
    busy_n = 0; done_n = 0; done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (c == 1) start = 1'b0;
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      busy_n += int'(busy);
      if (done) begin done_n++; done_at = c; end
      if (c == 1)  chk("t3_idx1", beep_idx, 0);
      if (c == 9)  chk("t3_gap_beep", beep, 0);
      if (c == 14) chk("t3_idx14", beep_idx, 1);
      if (c == 27) chk("t3_idx27", beep_idx, 2);
    end
    chk("t3_busy_cycles", busy_n, 34);
    chk("t3_done_count", done_n, 1);
    chk("t3_done_cycle", done_at, 35);

    // DC mode, zero gap.
    cfg(0, 10, 0, 2); start = 1'b1;
    high_n = 0; done_at = -1;
    for (int c = 1; c <= 25; c++) begin
      step();
      if (c == 1) start = 1'b0;
      high_n += int'(beep);
      if (done) done_at = c;
      if (c == 10) chk("t4_idx10", beep_idx, 0);
      if (c == 11) chk("t4_idx11", beep_idx, 1);
    end
    chk("t4_high_cycles", high_n, 20);
    chk("t4_done_cycle", done_at, 21);

    // Infinite mode, abort during the fifth beep.
    cfg(1, 6, 3, 0); start = 1'b1;
    for (int c = 1; c <= 41; c++) begin
      step();
      if (c == 1)  start = 1'b0;
      if (c == 37) begin chk("t5_idx37", beep_idx, 4); chk("t5_beep37", beep, 0); end
      if (c == 38) chk("t5_beep38", beep, 1);
      if (c == 39) abort = 1'b1;
      if (c == 40) begin
        abort = 1'b0;
        chk("t5_busy", busy, 0); chk("t5_done", done, 1);
        chk("t5_idx", beep_idx, 4); chk("t5_beep", beep, 0);
      end
      if (c == 41) begin chk("t5_done_pulse", done, 0); chk("t5_idx_hold", beep_idx, 4); end
    end

    // Infinite mode index wrap, then abort.
    cfg(3, 2, 0, 0); start = 1'b1;
    for (int c = 1; c <= 36; c++) begin
      step();
      if (c == 1)  start = 1'b0;
      if (c == 31) chk("wrap_idx31", beep_idx, 15);
      if (c == 33) chk("wrap_idx33", beep_idx, 0);
      if (c == 34) abort = 1'b1;
      if (c == 35) begin abort = 1'b0; chk("wrap_done", done, 1); chk("wrap_idx", beep_idx, 0); end
    end

    // Abort together with start in IDLE: start ignored.
    cfg(0, 4, 0, 1); start = 1'b1; abort = 1'b1;
    step(); chk("abst_busy1", busy, 0); chk("abst_done1", done, 0);
    step(); chk("abst_busy2", busy, 0);
    start = 1'b0; abort = 1'b0;
    step();

    // Start held high: one IDLE cycle between bursts.
    cfg(0, 3, 0, 1); start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      step();
      if (c == 4) begin chk("held_done4", done, 1); chk("held_busy4", busy, 0); end
      if (c == 5) begin chk("held_busy5", busy, 1); chk("held_idx5", beep_idx, 0); chk("held_beep5", beep, 1); start = 1'b0; end
      if (c == 8) chk("held_done8", done, 1);
    end

    // on_cycles == 0 is clamped to a single-cycle beep.
    cfg(1, 0, 7, 1); start = 1'b1;
    step(); start = 1'b0; chk("clamp_busy1", busy, 1); chk("clamp_beep1", beep, 0);
    step(); chk("clamp_done2", done, 1); chk("clamp_busy2", busy, 0);
    step(); chk("clamp_done3", done, 0);

    // Reset mid-burst: immediate, asynchronous, no done afterwards.
    cfg(2, 4, 0, 5); start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (c == 1) start = 1'b0;
    end
    chk("mid_idx_before", beep_idx, 2);
    chk("mid_busy_before", busy, 1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_beep", beep, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_idx", beep_idx, 0);
    step();
    rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
